// File: rtl/scoreboard_regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// The optional write-to-read bypass is selected by SCOREBOARD_REGFILE_BYPASS_EN.
package scoreboard_regfile_pkg;

   localparam int DEFAULT_BIT_COUNT       = 32;
   localparam int DEFAULT_REGISTER_COUNT  = 32;
   localparam int DEFAULT_READ_PORT_COUNT = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } sb_state_t;

endpackage

// File: rtl/scoreboard_busy_table.sv
// Pending-write flags, one per architectural register, with combinational
// lookups for every read port and the issue port. Register 0 is never busy.
module scoreboard_busy_table
   import scoreboard_regfile_pkg::*;
#(
   parameter int REGISTER_COUNT  = DEFAULT_REGISTER_COUNT,
   parameter int READ_PORT_COUNT = DEFAULT_READ_PORT_COUNT,
   localparam int AW             = $clog2(REGISTER_COUNT)
)(
   input  logic                                clk,
   input  logic                                srst,
   input  logic                                set_en,
   input  logic [AW-1:0]                       set_adr,
   input  logic                                clr_en,
   input  logic [AW-1:0]                       clr_adr,
   input  logic [READ_PORT_COUNT-1:0][AW-1:0]  rd_adr,
   output logic [READ_PORT_COUNT-1:0]          rd_busy,
   input  logic [AW-1:0]                       issue_adr,
   output logic                                issue_busy
);

   logic [REGISTER_COUNT-1:0] busy_reg;
   logic [REGISTER_COUNT-1:0] busy_next;

   assign busy_next[0] = 1'b0;

   // Set has priority over clear so a same-cycle issue and writeback leaves the flag up.
   genvar gi;
   generate
      for (gi = 1; gi < REGISTER_COUNT; gi++) begin : g_bit
         assign busy_next[gi] = (set_en && (set_adr == AW'(gi))) ? 1'b1 :
                                (clr_en && (clr_adr == AW'(gi))) ? 1'b0 :
                                busy_reg[gi];
      end
      for (gi = 0; gi < READ_PORT_COUNT; gi++) begin : g_lookup
         assign rd_busy[gi] = busy_reg[rd_adr[gi]];
      end
   endgenerate

   assign issue_busy = busy_reg[issue_adr];

   always_ff @(posedge clk) begin
      if (srst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy scoreboard and a zeroing sweep after reset.
// Define SCOREBOARD_REGFILE_BYPASS_EN to forward same-cycle writeback data to readers.
module scoreboard_regfile
   import scoreboard_regfile_pkg::*;
#(
   parameter int BIT_COUNT       = DEFAULT_BIT_COUNT,
   parameter int REGISTER_COUNT  = DEFAULT_REGISTER_COUNT,
   parameter int READ_PORT_COUNT = DEFAULT_READ_PORT_COUNT,
   localparam int AW             = $clog2(REGISTER_COUNT)
)(
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [READ_PORT_COUNT-1:0][AW-1:0]        RsAdr,
   output logic [READ_PORT_COUNT-1:0][BIT_COUNT-1:0] Rs,
   output logic [READ_PORT_COUNT-1:0]                RsBusy,
   input  logic                                      IssueEnable,
   input  logic [AW-1:0]                             IssueAdr,
   output logic                                      IssueReady,
   input  logic                                      WriteEnable,
   input  logic [AW-1:0]                             RdAdr,
   input  logic [BIT_COUNT-1:0]                      Rd,
   output logic                                      Ready
);

   sb_state_t              state_reg;
   logic [AW-1:0]          init_count_reg;
   logic                   ready_reg;
   logic [BIT_COUNT-1:0]   reg_mem [REGISTER_COUNT];

   logic                        run;
   logic                        sweeping;
   logic                        wr_fire;
   logic                        issue_busy;
   logic [READ_PORT_COUNT-1:0]  rd_busy;

   // Gating with reset keeps every output quiet while reset is held.
   assign run      = ready_reg && !reset;
   assign sweeping = (state_reg == INIT) && !reset;
   assign wr_fire  = run && WriteEnable && (RdAdr != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= INIT;
         init_count_reg <= '0;
         ready_reg      <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               init_count_reg <= init_count_reg + 1'b1;
               if (init_count_reg == AW'(REGISTER_COUNT - 1)) begin
                  state_reg <= RUN;
                  ready_reg <= 1'b1;
               end
            end
            RUN: begin
               ready_reg <= 1'b1;
            end
            default: begin
               state_reg <= INIT;
               ready_reg <= 1'b0;
            end
         endcase
      end
   end

   // Data array has no reset; the INIT sweep is the only thing that clears it.
   always_ff @(posedge clk) begin
      if (sweeping) begin
         reg_mem[init_count_reg] <= '0;
      end else if (wr_fire) begin
         reg_mem[RdAdr] <= Rd;
      end
   end

   assign IssueReady = run && (!issue_busy || (WriteEnable && (RdAdr == IssueAdr)));

   scoreboard_busy_table #(
      .REGISTER_COUNT  (REGISTER_COUNT),
      .READ_PORT_COUNT (READ_PORT_COUNT)
   ) u_busy_table (
      .clk        (clk),
      .srst       (reset),
      .set_en     (IssueEnable && IssueReady),
      .set_adr    (IssueAdr),
      .clr_en     (sweeping || wr_fire),
      .clr_adr    (sweeping ? init_count_reg : RdAdr),
      .rd_adr     (RsAdr),
      .rd_busy    (rd_busy),
      .issue_adr  (IssueAdr),
      .issue_busy (issue_busy)
   );

   genvar gi;
   generate
      for (gi = 0; gi < READ_PORT_COUNT; gi++) begin : g_read
         logic bypass_hit;
         logic live;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
         assign bypass_hit = WriteEnable && (RsAdr[gi] == RdAdr);
`else
         assign bypass_hit = 1'b0;
`endif
         assign live       = run && (RsAdr[gi] != '0);
         assign Rs[gi]     = !live     ? '0 :
                             bypass_hit ? Rd : reg_mem[RsAdr[gi]];
         assign RsBusy[gi] = live && !bypass_hit && rd_busy[gi];
      end
   endgenerate

   assign Ready = run;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomised and directed bench for scoreboard_regfile; a queue of expected
// per-cycle responses is drained by an independent monitor on the falling edge.
module tb_scoreboard_regfile;

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0][4:0]      RsAdr;
   logic [1:0][31:0]     Rs;
   logic [1:0]           RsBusy;
   logic                 IssueEnable;
   logic [4:0]           IssueAdr;
   logic                 IssueReady;
   logic                 WriteEnable;
   logic [4:0]           RdAdr;
   logic [31:0]          Rd;
   logic                 Ready;

   always #5 clk = ~clk;

   scoreboard_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .RsAdr       (RsAdr),
      .Rs          (Rs),
      .RsBusy      (RsBusy),
      .IssueEnable (IssueEnable),
      .IssueAdr    (IssueAdr),
      .IssueReady  (IssueReady),
      .WriteEnable (WriteEnable),
      .RdAdr       (RdAdr),
      .Rd          (Rd),
      .Ready       (Ready)
   );

   typedef struct packed {
      logic             ready;
      logic             iready;
      logic [1:0]       busy;
      logic [1:0][31:0] rs;
   } resp_t;

   resp_t       exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          txn    = 0;

   // Reference: architectural contents, pending flags, and remaining sweep cycles.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];
   int          m_init_left = 32;

   function automatic resp_t model_out();
      resp_t r;
      bit    run;
      run      = (m_init_left == 0) && !reset;
      r.ready  = run;
      r.iready = run && (!m_busy[IssueAdr] || (WriteEnable && RdAdr == IssueAdr));
      for (int p = 0; p < 2; p++) begin
         r.rs[p]   = 32'd0;
         r.busy[p] = 1'b0;
         if (run && RsAdr[p] != 5'd0) begin
            if (BYP && WriteEnable && RdAdr == RsAdr[p]) begin
               r.rs[p] = Rd;
            end else begin
               r.rs[p]   = m_mem[RsAdr[p]];
               r.busy[p] = m_busy[RsAdr[p]];
            end
         end
      end
      return r;
   endfunction

   task automatic model_edge(input resp_t r);
      if (reset) begin
         m_init_left = 32;
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (m_init_left > 0) begin
         m_mem[32 - m_init_left]  = 32'd0;
         m_busy[32 - m_init_left] = 1'b0;
         m_init_left--;
      end else begin
         if (WriteEnable && RdAdr != 5'd0) begin
            m_mem[RdAdr]  = Rd;
            m_busy[RdAdr] = 1'b0;
         end
         if (IssueEnable && r.iready && IssueAdr != 5'd0) m_busy[IssueAdr] = 1'b1;
      end
   endtask

   task automatic step(input logic rst, input logic ie, input logic [4:0] ia,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
      resp_t r;
      reset = rst; IssueEnable = ie; IssueAdr = ia;
      WriteEnable = we; RdAdr = wa; Rd = wd;
      RsAdr[0] = a0; RsAdr[1] = a1;
      r = model_out();
      exp_q.push_back(r);
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         resp_t e;
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d rst=%b ie=%b ia=%0d we=%b wa=%0d wd=%h a=%0d/%0d -> rdy=%b irdy=%b rs=%h/%h bsy=%b",
                  txn, reset, IssueEnable, IssueAdr, WriteEnable, RdAdr, Rd,
                  RsAdr[0], RsAdr[1], Ready, IssueReady, Rs[0], Rs[1], RsBusy);
         chk("ready",  {31'd0, Ready},      {31'd0, e.ready});
         chk("iready", {31'd0, IssueReady}, {31'd0, e.iready});
         chk("busy0",  {31'd0, RsBusy[0]},  {31'd0, e.busy[0]});
         chk("busy1",  {31'd0, RsBusy[1]},  {31'd0, e.busy[1]});
         chk("rs0",    Rs[0],               e.rs[0]);
         chk("rs1",    Rs[1],               e.rs[1]);
      end
   end

   initial begin
      reset = 1'b1; IssueEnable = 1'b0; IssueAdr = '0;
      WriteEnable = 1'b0; RdAdr = '0; Rd = '0; RsAdr = '0;
      @(posedge clk);
      #1;
      // Power-up reset, then the zeroing sweep with random reads.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 5, 9);
      idle(34);
      // Issue, blocked re-issue, writeback clears busy.
      step(0, 1, 5, 0, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0, 0, 0, 5);
      step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5);
      step(0, 0, 0, 0, 0, 0, 5, 5);
      // Issue and writeback to the same busy register in one cycle.
      step(0, 1, 7, 0, 0, 0, 7, 0);
      step(0, 1, 7, 1, 7, 32'h12, 7, 7);
      step(0, 0, 0, 0, 0, 0, 7, 7);
      // Register 0 ignores writes and issues.
      step(0, 1, 0, 1, 0, 32'hFFFF, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      // Same-cycle visibility of a write.
      step(0, 0, 0, 1, 3, 32'hA5, 3, 3);
      step(0, 0, 0, 0, 0, 0, 3, 3);
      // Reset mid-sweep, then again while x9 is busy.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(10);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(32);
      step(0, 1, 9, 1, 9, 32'h99, 9, 9);
      step(0, 0, 0, 0, 0, 0, 9, 9);
      step(1, 0, 0, 0, 0, 0, 9, 9);
      for (int i = 0; i < 34; i++) step(0, 0, 0, 0, 0, 0, 9, 9);
      // Random traffic concentrated on a few registers to force collisions.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] span;
         span = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
         step(($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, span)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, span)), $urandom,
              5'($urandom_range(0, span)), 5'($urandom_range(0, span)));
      end
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter BIT_COUNT, default 32, data width per register.
REQ-002 SHALL have parameter REGISTER_COUNT, default 32, number of architectural registers (power of 2, >= 2).
REQ-003 SHALL have parameter READ_PORT_COUNT, default 2, number of independent read ports (>= 1).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL provide reset  in  1  synchronous active-high reset.
REQ-006 SHALL provide RsAdr  in  READ_PORT_COUNT x AW  read addresses, where AW = $clog2(REGISTER_COUNT).
REQ-007 SHALL provide Rs  out  READ_PORT_COUNT x BIT_COUNT  read data.
REQ-008 SHALL provide RsBusy  out  READ_PORT_COUNT  pending-write flag per read port.
REQ-009 SHALL provide IssueEnable  in  1 and IssueAdr  in  AW, a request to mark a destination register busy.
REQ-010 SHALL provide IssueReady  out  1, meaning the issue is accepted this cycle.
REQ-011 SHALL provide WriteEnable  in  1, RdAdr  in  AW and Rd  in  BIT_COUNT as the writeback port.
REQ-012 SHALL provide Ready  out  1, high once initialisation is complete.

Function
REQ-013 SHALL implement a two-state FSM: INIT and RUN.
REQ-014 In INIT, SHALL write zero to register[InitCount] and clear busy[InitCount] each cycle, incrementing InitCount from 0.
REQ-015 SHALL move INIT->RUN on the cycle after InitCount = REGISTER_COUNT-1 is cleared; INIT therefore lasts exactly REGISTER_COUNT cycles.
REQ-016 In INIT, SHALL drive Ready=0, IssueReady=0, Rs=0 and RsBusy=0, and SHALL ignore WriteEnable and IssueEnable.
REQ-017 In RUN, Ready=1.
REQ-018 Reads SHALL be combinational: Rs[p] = register[RsAdr[p]] and RsBusy[p] = busy[RsAdr[p]], with zero added latency.
REQ-019 Register 0 SHALL always read 0 and never be busy; writes and issues to address 0 SHALL have no effect, and IssueReady SHALL be 1 for address 0 in RUN.
REQ-020 A writeback with WriteEnable=1 in RUN SHALL update register[RdAdr] to Rd at the clock edge and clear busy[RdAdr].
REQ-021 A write to a non-busy register SHALL be legal: the data updates and busy stays 0.
REQ-022 IssueReady SHALL equal RUN && (!busy[IssueAdr] || (WriteEnable && RdAdr==IssueAdr)).
REQ-023 An issue with IssueEnable && IssueReady SHALL set busy[IssueAdr] at the edge.
REQ-024 When an issue and a writeback hit the same register in one cycle, the register data SHALL update and busy SHALL end at 1 (set wins over clear).
REQ-025 An issue with IssueEnable=1 and IssueReady=0 SHALL change no state; the requester holds its request.
REQ-026 Multiple read ports addressing the same register SHALL return identical values.

Reset
REQ-027 reset=1 at a clock edge SHALL force INIT with InitCount=0 and all busy bits cleared, including when asserted mid-INIT or mid-RUN.
REQ-028 The register data array SHALL have no reset; it is cleared only by the INIT sweep.
REQ-029 While reset is held, outputs SHALL read as in INIT: Ready=0, IssueReady=0, Rs=0, RsBusy=0.

Configuration
REQ-030 When the macro SCOREBOARD_REGFILE_BYPASS_EN is defined, in RUN with WriteEnable=1 and RdAdr==RsAdr[p]!=0, the block SHALL drive Rs[p]=Rd and RsBusy[p]=0 in the same cycle.
REQ-031 When SCOREBOARD_REGFILE_BYPASS_EN is not defined, the block SHALL return pre-edge stored data and busy state, so the new value is visible the following cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (INIT, RUN) and the default-parameter constants.
REQ-033 Busy-bit tracking SHALL be a sub-module scoreboard_busy_table, with per-register set/clear and a combinational lookup per read port plus one lookup for the issue port.

Verification
REQ-034 Reset, then hold idle: Ready=0 for exactly 32 cycles and =1 on cycle 33; all reads return 0 with RsBusy=0.
REQ-035 Issue x5, then read x5 on port 1 next cycle -> RsBusy[1]=1; a second issue to x5 -> IssueReady=0; write x5=0xDEADBEEF -> next cycle Rs[1]=0xDEADBEEF, RsBusy[1]=0.
REQ-036 Same cycle: issue x7 and write x7=0x12 while x7 is busy -> IssueReady=1; next cycle x7 reads 0x12 with busy=1.
REQ-037 Write x0=0xFFFF and issue x0 -> x0 reads 0, RsBusy=0, IssueReady=1.
REQ-038 With BYPASS_EN defined, write x3=0xA5 while RsAdr[0]=3 -> Rs[0]=0xA5 in the same cycle; without it -> old value that cycle, 0xA5 the next.
REQ-039 Assert reset mid-INIT (cycle 10) and again in RUN with x9 busy -> Ready low for 32 more cycles, then x9 not busy and reading 0.
